// File: rtl/range_checked_ram_if.sv
// Bus bundle for range_checked_ram: init, limit programming, write and read
// channels plus the rejected-write counter.
interface range_checked_ram_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 2
);
   logic             init_req;
   logic             lim_wr;
   logic [AW-1:0]    lim_addr;
   logic [WIDTH-1:0] lim_min;
   logic [WIDTH-1:0] lim_max;
   logic             wr_req;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_done;
   logic             wr_ok;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_val;
   logic [7:0]       rej_cnt;

   modport master (
      output init_req, lim_wr, lim_addr, lim_min, lim_max,
      output wr_req, wr_addr, wr_data, rd_req, rd_addr,
      input  wr_done, wr_ok, rd_data, rd_val, rej_cnt
   );

   modport slave (
      input  init_req, lim_wr, lim_addr, lim_min, lim_max,
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
      output wr_done, wr_ok, rd_data, rd_val, rej_cnt
   );
endinterface

// File: rtl/range_checked_ram.sv
// range_checked_ram: flop-based WIDTH x DEPTH variable store where every entry
// carries its own unsigned [min,max] window. Writes are range-checked against
// the limits held before the edge and report committed/rejected one cycle later.
// Optional macro RCR_CLAMP_EN: out-of-window writes to a valid address are
// stored clamped to the window instead of being dropped (still reported rejected).
module range_checked_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input logic               clk,
   input logic               rst_n,
   range_checked_ram_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_A;
   endfunction

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [WIDTH-1:0] min_q  [DEPTH];
   logic [WIDTH-1:0] min_d  [DEPTH];
   logic [WIDTH-1:0] max_q  [DEPTH];
   logic [WIDTH-1:0] max_d  [DEPTH];

   logic             wr_done_q, wr_done_d;
   logic             wr_ok_q,   wr_ok_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_val_q,  rd_val_d;
   logic [7:0]       rej_cnt_q, rej_cnt_d;

   logic             wr_sel_ok;
   logic [WIDTH-1:0] wr_min, wr_max;
   logic             wr_in_rng;
   logic [WIDTH-1:0] rd_word;

   // Window lookup for the write address and the read word; invalid addresses
   // never index the arrays so non-power-of-two depths stay safe.
   always_comb begin
      wr_sel_ok = addr_ok(bus.wr_addr);
      wr_min    = wr_sel_ok ? min_q[bus.wr_addr] : '0;
      wr_max    = wr_sel_ok ? max_q[bus.wr_addr] : '0;
      wr_in_rng = wr_sel_ok && (wr_min <= bus.wr_data) && (bus.wr_data <= wr_max);
      rd_word   = addr_ok(bus.rd_addr) ? data_q[bus.rd_addr] : '0;
   end

`ifdef RCR_CLAMP_EN
   logic [WIDTH-1:0] clamp_val;
   // Inverted window (min > max) always lands on min.
   always_comb begin
      clamp_val = wr_max;
      if ((wr_min > wr_max) || (bus.wr_data < wr_min)) clamp_val = wr_min;
   end
`endif

   // Next-state: init clears storage and suppresses lim/wr; reads see old data.
   always_comb begin
      data_d    = data_q;
      min_d     = min_q;
      max_d     = max_q;
      wr_done_d = 1'b0;
      wr_ok_d   = 1'b0;
      rd_val_d  = bus.rd_req;
      rd_data_d = bus.rd_req ? rd_word : rd_data_q;
      rej_cnt_d = rej_cnt_q;
      if (bus.init_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = '0;
            min_d[i]  = '0;
            max_d[i]  = '1;
         end
      end else begin
         if (bus.lim_wr && addr_ok(bus.lim_addr)) begin
            min_d[bus.lim_addr] = bus.lim_min;
            max_d[bus.lim_addr] = bus.lim_max;
         end
         if (bus.wr_req) begin
            wr_done_d = 1'b1;
            wr_ok_d   = wr_in_rng;
            if (wr_in_rng) begin
               data_d[bus.wr_addr] = bus.wr_data;
            end else begin
               if (rej_cnt_q != 8'hFF) rej_cnt_d = rej_cnt_q + 8'd1;
`ifdef RCR_CLAMP_EN
               if (wr_sel_ok) data_d[bus.wr_addr] = clamp_val;
`endif
            end
         end
      end
   end

   // State registers; reset opens every window fully.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            min_q[i]  <= '0;
            max_q[i]  <= '1;
         end
         wr_done_q <= 1'b0;
         wr_ok_q   <= 1'b0;
         rd_data_q <= '0;
         rd_val_q  <= 1'b0;
         rej_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
            min_q[i]  <= min_d[i];
            max_q[i]  <= max_d[i];
         end
         wr_done_q <= wr_done_d;
         wr_ok_q   <= wr_ok_d;
         rd_data_q <= rd_data_d;
         rd_val_q  <= rd_val_d;
         rej_cnt_q <= rej_cnt_d;
      end
   end

   assign bus.wr_done = wr_done_q;
   assign bus.wr_ok   = wr_ok_q;
   assign bus.rd_data = rd_data_q;
   assign bus.rd_val  = rd_val_q;
   assign bus.rej_cnt = rej_cnt_q;
endmodule

// File: tb/tb_range_checked_ram.sv
// Testbench for range_checked_ram: directed scenarios plus randomized traffic
// against an array-based reference model of the store.
module tb_range_checked_ram;
   localparam int WIDTH = 16;
   localparam int DEPTH = 3;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   range_checked_ram_if #(.WIDTH(WIDTH), .AW(AW)) bus();
   range_checked_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   // reference model
   int m_data [DEPTH];
   int m_min  [DEPTH];
   int m_max  [DEPTH];
   int m_rej;
   // expectations for the cycle after the last step
   bit e_done, e_ok, e_rv;
   int e_rd;

   task automatic model_clear(input bit with_rej);
      for (int i = 0; i < DEPTH; i++) begin
         m_data[i] = 0; m_min[i] = 0; m_max[i] = 65535;
      end
      if (with_rej) m_rej = 0;
   endtask

   // Drive one cycle of stimulus from a negedge, advance the model, and return
   // at the following negedge with all strobes low.
   task automatic step(input bit init, input bit lw, input int la, input int lmin, input int lmax,
                       input bit w, input int wa, input int wd, input bit r, input int ra);
      bit ok;
      bus.init_req = init;
      bus.lim_wr = lw; bus.lim_addr = AW'(la); bus.lim_min = WIDTH'(lmin); bus.lim_max = WIDTH'(lmax);
      bus.wr_req = w;  bus.wr_addr = AW'(wa);  bus.wr_data = WIDTH'(wd);
      bus.rd_req = r;  bus.rd_addr = AW'(ra);
      e_rv = r;
      if (r) e_rd = (ra < DEPTH) ? m_data[ra] : 0;
      ok = 0;
      if (wa < DEPTH) ok = (m_min[wa] <= wd) && (wd <= m_max[wa]);
      e_done = w && !init;
      e_ok = e_done && ok;
      if (init) model_clear(0);
      else begin
         if (w) begin
            if (ok) m_data[wa] = wd;
            else begin
               if (m_rej < 255) m_rej++;
`ifdef RCR_CLAMP_EN
               if (wa < DEPTH) m_data[wa] = (m_min[wa] > m_max[wa] || wd < m_min[wa]) ? m_min[wa] : m_max[wa];
`endif
            end
         end
         if (lw && la < DEPTH) begin
            m_min[la] = lmin; m_max[la] = lmax;
         end
      end
      @(negedge clk);
      bus.init_req = 0; bus.lim_wr = 0; bus.wr_req = 0; bus.rd_req = 0;
   endtask

   task automatic test_reset();
      checks++; if (bus.wr_done !== 1'b0 || bus.rd_val !== 1'b0) begin errors++; $display("FAIL reset_strobes: got done=%b val=%b required 0 0", bus.wr_done, bus.rd_val); end
      checks++; if (bus.rd_data !== 16'h0 || bus.rej_cnt !== 8'h0) begin errors++; $display("FAIL reset_regs: got rd_data=%0h rej=%0d required 0 0", bus.rd_data, bus.rej_cnt); end
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 0,0,0, 1,a);
         checks++; if (bus.rd_val !== 1'b1 || bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL reset_read%0d: got val=%b data=%0h required 1 %0h", a, bus.rd_val, bus.rd_data, e_rd); end
         @(negedge clk);
         checks++; if (bus.rd_val !== 1'b0 || bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL reset_read_hold%0d: got val=%b data=%0h required 0 %0h", a, bus.rd_val, bus.rd_data, e_rd); end
      end
   endtask

   task automatic test_limits_writes();
      step(0, 1,0,1,1024,   0,0,0, 0,0);
      step(0, 1,1,32,65535, 0,0,0, 0,0);
      step(0, 1,2,1,65535,  0,0,0, 0,0);
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 1,a,(a == 1) ? 32 : 1, 0,0);
         checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== e_ok) begin errors++; $display("FAIL write_ok%0d: got done=%b ok=%b required 1 %b", a, bus.wr_done, bus.wr_ok, e_ok); end
      end
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 0,0,0, 1,a);
         checks++; if (bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL write_read%0d: got %0h required %0h", a, bus.rd_data, e_rd); end
      end
   endtask

   task automatic test_reject();
      step(0, 0,0,0,0, 1,1,31, 0,0);
      checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== 1'b0) begin errors++; $display("FAIL rej_low: got done=%b ok=%b required 1 0", bus.wr_done, bus.wr_ok); end
      step(0, 0,0,0,0, 1,0,1025, 1,1);
      checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== 1'b0) begin errors++; $display("FAIL rej_high: got done=%b ok=%b required 1 0", bus.wr_done, bus.wr_ok); end
      checks++; if (bus.rej_cnt !== 8'd2) begin errors++; $display("FAIL rej_cnt2: got %0d required 2", bus.rej_cnt); end
      checks++; if (bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL rej_read1: got %0h required %0h", bus.rd_data, e_rd); end
      step(0, 0,0,0,0, 0,0,0, 1,0);
      checks++; if (bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL rej_read0: got %0h required %0h", bus.rd_data, e_rd); end
   endtask

   task automatic test_bad_addr();
      step(0, 1,3,0,65535, 1,3,5, 0,0);
      checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== 1'b0) begin errors++; $display("FAIL bad_addr_wr: got done=%b ok=%b required 1 0", bus.wr_done, bus.wr_ok); end
      step(0, 0,0,0,0, 0,0,0, 1,3);
      checks++; if (bus.rd_val !== 1'b1 || bus.rd_data !== 16'h0) begin errors++; $display("FAIL bad_addr_rd: got val=%b data=%0h required 1 0", bus.rd_val, bus.rd_data); end
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 0,0,0, 1,a);
         checks++; if (bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL bad_addr_keep%0d: got %0h required %0h", a, bus.rd_data, e_rd); end
      end
   endtask

   task automatic test_same_cycle();
      // read+write same address also returns old data
      step(0, 1,0,10,20, 1,0,5, 1,0);
      checks++; if (bus.wr_ok !== 1'b1) begin errors++; $display("FAIL same_cyc_old_lim: got ok=%b required 1", bus.wr_ok); end
      checks++; if (bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL same_cyc_old_data: got %0h required %0h", bus.rd_data, e_rd); end
      step(0, 0,0,0,0, 1,0,5, 1,0);
      checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== 1'b0) begin errors++; $display("FAIL same_cyc_new_lim: got done=%b ok=%b required 1 0", bus.wr_done, bus.wr_ok); end
      checks++; if (bus.rd_data !== 16'd5) begin errors++; $display("FAIL same_cyc_data: got %0h required 5", bus.rd_data); end
   endtask

   task automatic test_back_to_back();
      int a, d;
      for (int i = 0; i < 12; i++) begin
         a = $urandom_range(0, 3); d = $urandom_range(0, 40);
         bus.wr_req = 1; bus.wr_addr = AW'(a); bus.wr_data = WIDTH'(d);
         step(0, 0,0,0,0, 1,a,d, 0,0);
         checks++; if (bus.wr_done !== 1'b1 || bus.wr_ok !== e_ok) begin errors++; $display("FAIL b2b%0d: got done=%b ok=%b required 1 %b", i, bus.wr_done, bus.wr_ok, e_ok); end
      end
      checks++; if (bus.rej_cnt !== 8'(m_rej)) begin errors++; $display("FAIL b2b_rej: got %0d required %0d", bus.rej_cnt, m_rej); end
   endtask

   task automatic test_random();
      bit in, lw, w, r;
      for (int i = 0; i < 400; i++) begin
         in = ($urandom_range(0, 49) == 0);
         lw = ($urandom_range(0, 3) == 0);
         w  = $urandom_range(0, 1);
         r  = $urandom_range(0, 1);
         step(in, lw, $urandom_range(0, 3), $urandom_range(0, 200), $urandom_range(0, 400),
              w, $urandom_range(0, 3), $urandom_range(0, 450), r, $urandom_range(0, 3));
         checks++; if (bus.wr_done !== e_done || (e_done && bus.wr_ok !== e_ok)) begin errors++; $display("FAIL rnd_wr%0d: got done=%b ok=%b required %b %b", i, bus.wr_done, bus.wr_ok, e_done, e_ok); end
         checks++; if (bus.rd_val !== e_rv || bus.rd_data !== 16'(e_rd)) begin errors++; $display("FAIL rnd_rd%0d: got val=%b data=%0h required %b %0h", i, bus.rd_val, bus.rd_data, e_rv, e_rd); end
         checks++; if (bus.rej_cnt !== 8'(m_rej)) begin errors++; $display("FAIL rnd_rej%0d: got %0d required %0d", i, bus.rej_cnt, m_rej); end
      end
   endtask

   task automatic test_saturate_init();
      for (int i = 0; i < 300; i++) step(0, 0,0,0,0, 1,3,i, 0,0);
      checks++; if (bus.rej_cnt !== 8'd255 || m_rej != 255) begin errors++; $display("FAIL sat: got %0d required 255", bus.rej_cnt); end
      step(0, 1,2,7,7, 1,2,7, 0,0);
      step(1, 1,1,0,0, 1,0,3, 1,2);
      checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL init_no_done: got %b required 0", bus.wr_done); end
      checks++; if (bus.rd_data !== 16'd7 || bus.rd_val !== 1'b1) begin errors++; $display("FAIL init_pre_clear_rd: got %0h required 7", bus.rd_data); end
      checks++; if (bus.rej_cnt !== 8'd255) begin errors++; $display("FAIL init_keeps_rej: got %0d required 255", bus.rej_cnt); end
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 0,0,0, 1,a);
         checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL init_clear%0d: got %0h required 0", a, bus.rd_data); end
      end
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0,0,0,0, 1,a,(a == 0) ? 65535 : 0, 0,0);
         checks++; if (bus.wr_ok !== 1'b1) begin errors++; $display("FAIL init_limits%0d: got ok=%b required 1", a, bus.wr_ok); end
      end
   endtask

   task automatic test_async_reset();
      bus.wr_req = 1; bus.wr_addr = 2'd3; bus.wr_data = 16'd1;
      @(posedge clk); #1;
      bus.wr_req = 0;
      checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL arst_pre: got done=%b required 1", bus.wr_done); end
      rst_n = 1'b0; #1;
      checks++; if (bus.wr_done !== 1'b0 || bus.wr_ok !== 1'b0 || bus.rej_cnt !== 8'd0 || bus.rd_data !== 16'd0) begin errors++; $display("FAIL arst: got done=%b ok=%b rej=%0d rd=%0h required 0 0 0 0", bus.wr_done, bus.wr_ok, bus.rej_cnt, bus.rd_data); end
      model_clear(1); e_rd = 0;
      @(negedge clk); rst_n = 1'b1;
      step(0, 0,0,0,0, 1,1,65535, 1,0);
      checks++; if (bus.wr_ok !== 1'b1 || bus.rd_data !== 16'h0) begin errors++; $display("FAIL arst_after: got ok=%b rd=%0h required 1 0", bus.wr_ok, bus.rd_data); end
   endtask

   initial begin
      bus.init_req = 0; bus.lim_wr = 0; bus.lim_addr = '0; bus.lim_min = '0; bus.lim_max = '0;
      bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_req = 0; bus.rd_addr = '0;
      model_clear(1); e_rd = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_limits_writes();
      test_reject();
      test_bad_addr();
      test_same_cycle();
      test_back_to_back();
      test_random();
      test_saturate_init();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
